// File: rtl/lambert_shader.sv
// Multi-light fixed-point Lambertian shading stage: N.L x intensity per light, albedo scaled.
// Define LAMBERT_AMBIENT_EN to add the AMBIENT floor to the accumulated shade.
module lambert_shader #(
    parameter int          WIDTH      = 32,
    parameter int          NUM_LIGHTS = 4,
    parameter logic [23:0] ALBEDO0    = 24'hFF8040,
    parameter logic [23:0] ALBEDO1    = 24'h40C0FF,
    parameter logic [7:0]  AMBIENT    = 8'd32,
    localparam int         IDX_W      = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [2:0][WIDTH-1:0]   normal_axis_tdata,
    input  logic                    normal_axis_tuser,
    input  logic                    normal_axis_tvalid,
    output logic                    normal_axis_tready,
    input  logic                    light_wr_en,
    input  logic [IDX_W-1:0]        light_wr_idx,
    input  logic [2:0][WIDTH-1:0]   light_wr_dir,
    input  logic [7:0]              light_wr_intensity,
    input  logic                    light_wr_enable,
    output logic                    light_wr_ready,
    output logic [23:0]             pixel_axis_tdata,
    output logic                    pixel_axis_tvalid,
    input  logic                    pixel_axis_tready
);

    localparam int F     = WIDTH - 2;
    localparam int DW    = 2 * WIDTH + 2;
    localparam int ACC_W = $clog2(NUM_LIGHTS * 255 + 256) + 1;
    localparam logic signed [DW-1:0] ONE_D = DW'(1) << F;

    typedef enum logic [1:0] {IDLE, DOT, SCALE, OUT} state_t;

    state_t                  state, state_nxt;
    logic [2:0][WIDTH-1:0]   n_q;
    logic                    mat_q;
    logic [ACC_W-1:0]        acc_q;
    logic [IDX_W-1:0]        idx_q;
    logic [23:0]             pixel_q;

    logic [2:0][WIDTH-1:0]   lt_dir [NUM_LIGHTS];
    logic [7:0]              lt_int [NUM_LIGHTS];
    logic                    lt_en  [NUM_LIGHTS];
    logic                    wr_hit;

    logic signed [2*WIDTH-1:0] term [3];
    logic signed [DW-1:0]      dot_full, dot_sh;
    logic [F:0]                dot_clamp;
    logic [F+7:0]              lit_prod;
    logic [7:0]                contrib;

    logic [ACC_W:0]          shade_sum;
    logic [7:0]              shade;
    logic [8:0]              shade_p1;
    logic [23:0]             albedo, shaded;
    logic [15:0]             ch_prod [3];
    logic                    unused_bits;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Handshake outputs depend on state alone, so pixel_axis_tready never reaches an output combinationally.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
        state_nxt          = state;
        normal_axis_tready = 1'b0;
        light_wr_ready     = 1'b0;
        pixel_axis_tvalid  = 1'b0;
        case (state)
            IDLE: begin
                normal_axis_tready = 1'b1;
                light_wr_ready     = 1'b1;
                if (normal_axis_tvalid) state_nxt = DOT;
            end
            DOT:   if (idx_q == IDX_W'(NUM_LIGHTS - 1)) state_nxt = SCALE;
            SCALE: state_nxt = OUT;
            OUT: begin
                pixel_axis_tvalid = 1'b1;
                if (pixel_axis_tready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_hit = light_wr_en && (state == IDLE) &&
                    ({1'b0, light_wr_idx} < (IDX_W + 1)'(NUM_LIGHTS));

    // NOTE: the light table is a handful of registers and must come up disabled, so it is reset like any other state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_LIGHTS; i++) begin
                lt_dir[i] <= '0;
                lt_int[i] <= '0;
                lt_en[i]  <= 1'b0;
            end
        end else if (wr_hit) begin
            lt_dir[light_wr_idx] <= light_wr_dir;
            lt_int[light_wr_idx] <= light_wr_intensity;
            lt_en[light_wr_idx]  <= light_wr_enable;
        end
    end

    // One light per DOT cycle: full-precision dot product, rescale to Q2.F, clamp to [0, 1.0].
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            term[k] = (2*WIDTH)'($signed(n_q[k])) * (2*WIDTH)'($signed(lt_dir[idx_q][k]));
        end
        dot_full = DW'(term[0]) + DW'(term[1]) + DW'(term[2]);
        dot_sh   = dot_full >>> F;
        if (dot_sh[DW-1])        dot_clamp = '0;
        else if (dot_sh > ONE_D) dot_clamp = ONE_D[F:0];
        else                     dot_clamp = dot_sh[F:0];
        lit_prod = (F + 8)'(dot_clamp) * (F + 8)'(lt_int[idx_q]);
        contrib  = lt_en[idx_q] ? lit_prod[F+7:F] : 8'd0;
    end

    always_comb begin
`ifdef LAMBERT_AMBIENT_EN
        shade_sum = (ACC_W + 1)'(acc_q) + (ACC_W + 1)'(AMBIENT);
`else
        shade_sum = (ACC_W + 1)'(acc_q);
`endif
        shade    = (shade_sum > (ACC_W + 1)'(255)) ? 8'hFF : shade_sum[7:0];
        shade_p1 = {1'b0, shade} + 9'd1;
        albedo   = mat_q ? ALBEDO1 : ALBEDO0;
        shaded   = '0;
        for (int c = 0; c < 3; c++) begin
            ch_prod[c]          = 16'(albedo[8*c +: 8]) * 16'(shade_p1);
            shaded[8*c +: 8]    = ch_prod[c][15:8];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            n_q     <= '0;
            mat_q   <= 1'b0;
            acc_q   <= '0;
            idx_q   <= '0;
            pixel_q <= '0;
        end else begin
            case (state)
                IDLE: if (normal_axis_tvalid) begin
                    n_q   <= normal_axis_tdata;
                    mat_q <= normal_axis_tuser;
                    acc_q <= '0;
                    idx_q <= '0;
                end
                DOT: begin
                    acc_q <= acc_q + ACC_W'(contrib);
                    idx_q <= idx_q + IDX_W'(1);
                end
                SCALE:   pixel_q <= shaded;
                default: ;
            endcase
        end
    end

    assign pixel_axis_tdata = pixel_q;

    // Fractional bits discarded by the >>F and >>8 rescales.
    assign unused_bits = ^{lit_prod[F-1:0], ch_prod[0][7:0], ch_prod[1][7:0], ch_prod[2][7:0]};

endmodule

// File: tb/tb_lambert_shader.sv
// Self-checking bench for lambert_shader: directed cases plus randomized lights/normals vs a behavioural model.
module tb_lambert_shader;

    localparam int     W   = 32;
    localparam int     NL  = 4;
    localparam int     F   = W - 2;
    localparam longint ONE = longint'(1) <<< F;
`ifdef LAMBERT_AMBIENT_EN
    localparam logic [23:0] DARK = 24'h201008;
`else
    localparam logic [23:0] DARK = 24'h000000;
`endif

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [2:0][W-1:0] normal_axis_tdata;
    logic              normal_axis_tuser, normal_axis_tvalid, normal_axis_tready;
    logic              light_wr_en;
    logic [1:0]        light_wr_idx;
    logic [2:0][W-1:0] light_wr_dir;
    logic [7:0]        light_wr_intensity;
    logic              light_wr_enable, light_wr_ready;
    logic [23:0]       pixel_axis_tdata;
    logic              pixel_axis_tvalid, pixel_axis_tready;

    int     n_checks = 0;
    int     n_pass   = 0;
    longint m_dir [NL][3];
    int     m_int [NL];
    bit     m_en  [NL];
    bit     co_write;

    lambert_shader #(.WIDTH(W), .NUM_LIGHTS(NL)) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .normal_axis_tdata  (normal_axis_tdata),
        .normal_axis_tuser  (normal_axis_tuser),
        .normal_axis_tvalid (normal_axis_tvalid),
        .normal_axis_tready (normal_axis_tready),
        .light_wr_en        (light_wr_en),
        .light_wr_idx       (light_wr_idx),
        .light_wr_dir       (light_wr_dir),
        .light_wr_intensity (light_wr_intensity),
        .light_wr_enable    (light_wr_enable),
        .light_wr_ready     (light_wr_ready),
        .pixel_axis_tdata   (pixel_axis_tdata),
        .pixel_axis_tvalid  (pixel_axis_tvalid),
        .pixel_axis_tready  (pixel_axis_tready)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NL; i++) begin
            m_dir[i] = '{0, 0, 0};
            m_int[i] = 0;
            m_en[i]  = 1'b0;
        end
    endtask

    // Shading rules in plain integer arithmetic.
    function automatic logic [23:0] model_pixel(input longint nx, input longint ny,
                                                input longint nz, input bit mat);
        longint acc, d, shade, c;
        logic [23:0] alb, px;
        acc = 0;
        for (int i = 0; i < NL; i++) begin
            d = (nx * m_dir[i][0] + ny * m_dir[i][1] + nz * m_dir[i][2]) >>> F;
            if (d < 0) d = 0;
            else if (d > ONE) d = ONE;
            if (m_en[i]) acc += (d * m_int[i]) >>> F;
        end
        shade = acc;
`ifdef LAMBERT_AMBIENT_EN
        shade += 32;
`endif
        if (shade > 255) shade = 255;
        alb = mat ? 24'h40C0FF : 24'hFF8040;
        px  = '0;
        for (int ch = 0; ch < 3; ch++) begin
            c = longint'(alb[8*ch +: 8]);
            px[8*ch +: 8] = 8'((c * (shade + 1)) >> 8);
        end
        return px;
    endfunction

    task automatic set_light(input int idx, input longint x, input longint y, input longint z,
                             input int inten, input bit en);
        light_wr_idx       = 2'(idx);
        light_wr_dir       = {W'(z), W'(y), W'(x)};
        light_wr_intensity = 8'(inten);
        light_wr_enable    = en;
        m_dir[idx] = '{x, y, z};
        m_int[idx] = inten;
        m_en[idx]  = en;
    endtask

    task automatic write_light(input int idx, input longint x, input longint y, input longint z,
                               input int inten, input bit en);
        @(negedge aclk);
        set_light(idx, x, y, z, inten, en);
        light_wr_en = 1'b1;
        check("wr_ready_idle", light_wr_ready, 1);
        @(negedge aclk);
        light_wr_en = 1'b0;
    endtask

    // Sends one normal, checks latency, pixel value and handshake behaviour; exp_lit >= 0 overrides the model.
    task automatic run_pixel(input longint nx, input longint ny, input longint nz, input bit mat,
                             input int stall, input longint exp_lit);
        logic [23:0] exp;
        int lat;
        bit seen;
        exp = (exp_lit >= 0) ? 24'(exp_lit) : model_pixel(nx, ny, nz, mat);
        @(negedge aclk);
        normal_axis_tdata  = {W'(nz), W'(ny), W'(nx)};
        normal_axis_tuser  = mat;
        normal_axis_tvalid = 1'b1;
        light_wr_en        = co_write;
        pixel_axis_tready  = (stall == 0);
        lat = 0;
        while (!normal_axis_tready && lat < 20) begin
            @(negedge aclk);
            lat++;
        end
        check("in_ready", normal_axis_tready, 1);
        @(posedge aclk);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge aclk);
            lat++;
            if (lat == 1) begin
                normal_axis_tvalid = 1'b0;
                light_wr_en        = 1'b0;
                co_write           = 1'b0;
            end
            seen = pixel_axis_tvalid;
        end
        check("latency", lat, NL + 2);
        check("pixel", pixel_axis_tdata, exp);
        for (int s = 0; s < stall; s++) begin
            if (s == 1) begin
                // Write attempted while busy: the model is deliberately not updated.
                light_wr_idx       = 2'd0;
                light_wr_dir       = '0;
                light_wr_intensity = 8'd0;
                light_wr_enable    = 1'b0;
                light_wr_en        = 1'b1;
            end
            if (s == 2) light_wr_en = 1'b0;
            @(negedge aclk);
            check("stall_tvalid", pixel_axis_tvalid, 1);
            check("stall_tdata", pixel_axis_tdata, exp);
            check("stall_in_ready", normal_axis_tready, 0);
            check("stall_wr_ready", light_wr_ready, 0);
        end
        light_wr_en       = 1'b0;
        pixel_axis_tready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        check("post_in_ready", normal_axis_tready, 1);
        check("post_tvalid", pixel_axis_tvalid, 0);
    endtask

    function automatic longint rnd_comp();
        return longint'($urandom_range(32'h8000_0000, 0)) - ONE;
    endfunction

    initial begin
        bit seen;
        aresetn            = 1'b0;
        normal_axis_tdata  = '0;
        normal_axis_tuser  = 1'b0;
        normal_axis_tvalid = 1'b0;
        light_wr_en        = 1'b0;
        light_wr_idx       = '0;
        light_wr_dir       = '0;
        light_wr_intensity = '0;
        light_wr_enable    = 1'b0;
        pixel_axis_tready  = 1'b1;
        co_write           = 1'b0;
        clear_model();

        repeat (3) @(negedge aclk);
        check("reset_tvalid", pixel_axis_tvalid, 0);
        check("reset_tdata", pixel_axis_tdata, 0);
        check("reset_in_ready", normal_axis_tready, 1);
        check("reset_wr_ready", light_wr_ready, 1);
        aresetn = 1'b1;

        // Directed cases with literal expected pixels.
        write_light(0, 0, 0, ONE, 255, 1'b1);
        run_pixel(0, 0, ONE, 1'b0, 0, 24'hFF8040);
        run_pixel(0, 0, 64'sh2000_0000, 1'b0, 0, 24'h7F4020);
        run_pixel(0, 0, -ONE, 1'b0, 0, DARK);
        write_light(0, 0, 0, ONE, 200, 1'b1);
        write_light(1, 0, 0, ONE, 200, 1'b1);
        run_pixel(0, 0, ONE, 1'b1, 0, 24'h40C0FF);

        // Light write in the same cycle as the input handshake feeds that pixel.
        @(negedge aclk);
        set_light(2, ONE, 0, 0, 100, 1'b1);
        co_write = 1'b1;
        run_pixel(ONE, 0, 0, 1'b0, 0, -1);

        // Output stall with a busy-time write, then the old table must still apply.
        run_pixel(0, 0, ONE, 1'b0, 5, 24'hFF8040);
        run_pixel(0, 0, ONE, 1'b0, 0, 24'hFF8040);

        // Randomized tables and normals.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NL; i++)
                write_light(i, rnd_comp(), rnd_comp(), rnd_comp(),
                            int'($urandom_range(255, 0)), 1'($urandom_range(1, 0)));
            for (int p = 0; p < 6; p++)
                run_pixel(rnd_comp(), rnd_comp(), rnd_comp(), 1'($urandom_range(1, 0)),
                          int'($urandom_range(2, 0)), -1);
        end

        // Reset during DOT discards the pixel and clears the table.
        write_light(0, 0, 0, ONE, 255, 1'b1);
        run_pixel(0, 0, ONE, 1'b0, 0, -1);
        @(negedge aclk);
        normal_axis_tdata  = {W'(ONE), W'(0), W'(0)};
        normal_axis_tuser  = 1'b0;
        normal_axis_tvalid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        normal_axis_tvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check("midrst_tvalid", pixel_axis_tvalid, 0);
        check("midrst_tdata", pixel_axis_tdata, 0);
        check("midrst_in_ready", normal_axis_tready, 1);
        check("midrst_wr_ready", light_wr_ready, 1);
        clear_model();
        @(negedge aclk);
        aresetn = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge aclk);
            if (pixel_axis_tvalid) seen = 1'b1;
        end
        check("no_stray_pixel", seen, 0);
        run_pixel(0, 0, ONE, 1'b0, 0, DARK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
